mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle RV32I control unit: FSM sequencing fetch/decode/execute/mem/writeback for all RV32I
//  integer, load/store (byte/half/word), branch, jal, jalr, lui, auipc. Drives datapath mux selects
//  and write enables; memory accesses use a ready handshake. Sits between IR fields and datapath.
// PARAMETERS
//  ALU_OP_W  4  width of alu_op; encoding {funct7[5],funct3}, upper bits zero-filled
//  STATE_W   5  width of state register / state_o
//  MEM_HS    1  1: fetch/load/store states wait for mem_ready; 0: mem_ready ignored, 1 cycle
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active-low
//  opcode     in   7         IR[6:0];  funct3 in 3 IR[14:12];  funct7 in 7 IR[31:25]
//  zf/lt/ltu  in   1 each    ALU flags: equal, signed less-than, unsigned less-than (valid in BR_CMP)
//  mem_ready  in   1         memory op completes this cycle
//  alu_op     out  ALU_OP_W  ALU function;  alu_a_sel out 1 (0 rs1,1 pc);  alu_b_sel out 2 (0 rs2,1 imm,2 const 4)
//  wb_sel     out  2         0 alu,1 imm,2 mem,3 pc+4
//  pc_sel     out  1         0 alu result, 1 branch/jump target register
//  reg_write/ir_write/pc_write/mem_read/mem_write  out 1 each   datapath strobes
//  mem_size   out  2         funct3[1:0] during loads/stores, else 2'b10
//  illegal    out  1         sticky illegal-instruction flag (see CONFIGURATION)
//  state_o    out  STATE_W   current state, debug
// BEHAVIOUR
//  - Outputs are Moore: decoded combinationally from registered state only. Reset: state IDLE, all
//    outputs 0, mem_size 2'b10, illegal 0. Reset mid-instruction aborts immediately, no write issued.
//  - IDLE->FETCH unconditionally next cycle. FETCH: mem_read=1, ir_write=pc_write=1 with alu
//    computing pc+4 (alu_a_sel=1, alu_b_sel=2, alu_op=0); held until mem_ready (MEM_HS=1) -> DECODE.
//    ir_write/pc_write asserted only in the cycle mem_ready=1.
//  - DECODE: alu computes pc+imm (target latched by datapath). Next by opcode:
//    0110011->EXEC_R, 0010011->EXEC_I, 0110111->LUI, 0010111->AUIPC, 0000011/0100011->MEM_ADDR,
//    1101111->JAL, 1100111(f3=000)->JALR, 1100011->BR_CMP, else ILLEGAL.
//  - EXEC_R: alu_op={f7[5],f3}. EXEC_I: alu_op={f3==101?f7[5]:0,f3}, alu_b_sel=1. Both ->WB_ALU
//    (reg_write=1,wb_sel=0)->FETCH. funct7 not 0000000/0100000 (R), or bad shift f7 -> ILLEGAL.
//  - LUI: reg_write, wb_sel=1 ->FETCH. AUIPC: alu pc+imm ->WB_ALU.
//  - MEM_ADDR: alu rs1+imm ->MEM_RD (load f3 in {000,001,010,100,101}) / MEM_WR (store f3 in
//    {000,001,010}) / ILLEGAL otherwise. MEM_RD: mem_read=1 until mem_ready ->MEM_WB (reg_write,
//    wb_sel=2)->FETCH. MEM_WR: mem_write=1 until mem_ready ->FETCH. Exactly one strobe cycle per
//    access seen by memory at the ready cycle; no double write on stall.
//  - JAL: reg_write,wb_sel=3,pc_write,pc_sel=1 ->FETCH. JALR: alu rs1+imm, reg_write,wb_sel=3,
//    pc_write,pc_sel=0 ->FETCH (bit0 clearing done in datapath). rd=x0 suppression is datapath's job.
//  - BR_CMP: alu_op=SUB (4'b1000), alu_b_sel=0 ->BR_DONE. BR_DONE: pc_write=taken, pc_sel=1, where
//    taken = f3 000 zf,001 !zf,100 lt,101 !lt,110 ltu,111 !ltu; f3 010/011 -> ILLEGAL from BR_CMP.
//  - Flags sampled in BR_DONE (registered ALU path). Latency (MEM_HS=0): R/I 4, lui/jal/jalr 3,
//    load 5, store 4, branch 4 cycles incl. fetch.
// CONFIGURATION
//  MC_CTRL_TRAP_EN defined: ILLEGAL state sets illegal=1 and stays in TRAP (all strobes 0) until reset.
//  Undefined: ILLEGAL is a one-cycle NOP state -> FETCH (instruction skipped, PC already +4);
//  illegal pulses 1 for that cycle only.
// STRUCTURE
//  Package mc_ctrl_pkg: state enum localparams, opcode constants, ALU_ADD/ALU_SUB, wb_sel/alu_b_sel
//  codes. Single sub-module mc_ctrl_branch_eval (funct3+flags -> taken, valid). FSM + output decode here.
// TESTING
//  1 add x3,x1,x2 (0x002081B3), MEM_HS=0 -> states FETCH,DECODE,EXEC_R,WB_ALU; alu_op=0000, reg_write 1 cycle.
//  2 lw (0x0000A103), mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, single reg_write, wb_sel=2.
//  3 bne f3=001 with zf=0 -> pc_write=1 in BR_DONE; zf=1 -> pc_write=0; f3=010 -> illegal.
//  4 sw f3=010, mem_ready at 2nd cycle -> mem_write high 2 cycles, returns to FETCH, reg_write never 1.
//  5 opcode 7'h7F: TRAP_EN -> illegal sticky, no strobes for 20 cycles; no macro -> 1-cycle pulse, FETCH.
//  6 rst_n low in MEM_WR while waiting -> all outputs 0 same cycle; after release IDLE then FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit (mc_ctrl_fsm).
//   state_e        FSM state encoding, also exported on state_o for debug
//   Op*            RV32I major opcodes recognised in DECODE
//   ALU_ADD/SUB    alu_op codes the FSM forces outside EXEC_R/EXEC_I
//   WbSel*/BSel*   wb_sel and alu_b_sel mux codes
// Build option: MC_CTRL_TRAP_EN (see mc_ctrl_fsm.sv).
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    StIdle    = 5'd0,
    StFetch   = 5'd1,
    StDecode  = 5'd2,
    StExecR   = 5'd3,
    StExecI   = 5'd4,
    StLui     = 5'd5,
    StAuipc   = 5'd6,
    StWbAlu   = 5'd7,
    StMemAddr = 5'd8,
    StMemRd   = 5'd9,
    StMemWb   = 5'd10,
    StMemWr   = 5'd11,
    StJal     = 5'd12,
    StJalr    = 5'd13,
    StBrCmp   = 5'd14,
    StBrDone  = 5'd15,
    StIllegal = 5'd16
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelImm = 2'd1;
  localparam logic [1:0] WbSelMem = 2'd2;
  localparam logic [1:0] WbSelPc4 = 2'd3;

  localparam logic [1:0] BSelRs2  = 2'd0;
  localparam logic [1:0] BSelImm  = 2'd1;
  localparam logic [1:0] BSelFour = 2'd2;

  // lb, lh, lw, lbu, lhu
  function automatic logic load_f3_ok(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // sb, sh, sw
  function automatic logic store_f3_ok(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle.
//   Datapath -> control: opcode/funct3/funct7 (IR fields), zf/lt/ltu (ALU flags), mem_ready
//   Control -> datapath: ALU/mux selects, write strobes, mem_size, illegal, state_o (debug)
// Modports: master = control unit, slave = datapath side.
interface mc_ctrl_fsm_if #(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned STATE_W  = 5
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                zf;
  logic                lt;
  logic                ltu;
  logic                mem_ready;

  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_a_sel;
  logic [1:0]          alu_b_sel;
  logic [1:0]          wb_sel;
  logic                pc_sel;
  logic                reg_write;
  logic                ir_write;
  logic                pc_write;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          mem_size;
  logic                illegal;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  opcode, funct3, funct7, zf, lt, ltu, mem_ready,
    output alu_op, alu_a_sel, alu_b_sel, wb_sel, pc_sel, reg_write, ir_write, pc_write,
           mem_read, mem_write, mem_size, illegal, state_o
  );

  modport slave (
    output opcode, funct3, funct7, zf, lt, ltu, mem_ready,
    input  alu_op, alu_a_sel, alu_b_sel, wb_sel, pc_sel, reg_write, ir_write, pc_write,
           mem_read, mem_write, mem_size, illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl_branch_eval.sv
// Branch condition evaluation from funct3 and registered ALU flags.
//   funct3_i  branch funct3;  zf_i/lt_i/ltu_i  equal, signed lt, unsigned lt
//   taken_o   condition holds;  valid_o  funct3 is a defined branch (010/011 are not)
module mc_ctrl_branch_eval (
  input  logic [2:0] funct3_i,
  input  logic       zf_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       valid_o
);

  always_comb begin
    taken_o = 1'b0;
    valid_o = 1'b1;
    case (funct3_i)
      3'b000:  taken_o = zf_i;
      3'b001:  taken_o = ~zf_i;
      3'b100:  taken_o = lt_i;
      3'b101:  taken_o = ~lt_i;
      3'b110:  taken_o = ltu_i;
      3'b111:  taken_o = ~ltu_i;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit. Sequences fetch/decode/execute/mem/writeback and drives
// datapath selects and strobes. Outputs are decoded from the registered state only, except
// the FETCH ir_write/pc_write strobes which qualify on mem_ready so the IR/PC load once.
// Ports: clk, rst_n (async, active-low), bus (mc_ctrl_fsm_if.master).
// Parameters: ALU_OP_W, STATE_W, MEM_HS (1: memory states wait for mem_ready).
// Build option: MC_CTRL_TRAP_EN -- illegal instructions park in ILLEGAL with illegal=1 until
// reset; otherwise ILLEGAL is a one-cycle NOP returning to FETCH with a one-cycle illegal pulse.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned STATE_W  = 5,
  parameter bit          MEM_HS   = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  state_e     state_q, state_d;
  logic       mem_done;
  logic       br_taken, br_valid;
  logic       r_f7_ok, i_f7_ok;
  logic [3:0] alu_op4;

  assign mem_done = MEM_HS ? bus.mem_ready : 1'b1;

  mc_ctrl_branch_eval u_branch_eval (
    .funct3_i (bus.funct3),
    .zf_i     (bus.zf),
    .lt_i     (bus.lt),
    .ltu_i    (bus.ltu),
    .taken_o  (br_taken),
    .valid_o  (br_valid)
  );

  assign r_f7_ok = (bus.funct7 == 7'b0000000) || (bus.funct7 == 7'b0100000);

  // Only the shift-immediates constrain funct7; other OP-IMM forms carry immediate bits there.
  always_comb begin
    case (bus.funct3)
      3'b001:  i_f7_ok = (bus.funct7 == 7'b0000000);
      3'b101:  i_f7_ok = r_f7_ok;
      default: i_f7_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_done) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpR:             state_d = r_f7_ok ? StExecR : StIllegal;
          OpImm:           state_d = i_f7_ok ? StExecI : StIllegal;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          OpLoad, OpStore: state_d = StMemAddr;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = (bus.funct3 == 3'b000) ? StJalr : StIllegal;
          OpBranch:        state_d = StBrCmp;
          default:         state_d = StIllegal;
        endcase
      end
      StExecR, StExecI, StAuipc: state_d = StWbAlu;
      StWbAlu, StLui, StJal, StJalr, StMemWb, StBrDone: state_d = StFetch;
      StMemAddr: begin
        if ((bus.opcode == OpLoad) && load_f3_ok(bus.funct3)) begin
          state_d = StMemRd;
        end else if ((bus.opcode == OpStore) && store_f3_ok(bus.funct3)) begin
          state_d = StMemWr;
        end else begin
          state_d = StIllegal;
        end
      end
      StMemRd:  if (mem_done) state_d = StMemWb;
      StMemWr:  if (mem_done) state_d = StFetch;
      StBrCmp:  state_d = br_valid ? StBrDone : StIllegal;
`ifdef MC_CTRL_TRAP_EN
      StIllegal: state_d = StIllegal;
`else
      StIllegal: state_d = StFetch;
`endif
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    alu_op4       = ALU_ADD;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = BSelRs2;
    bus.wb_sel    = WbSelAlu;
    bus.pc_sel    = 1'b0;
    bus.reg_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_size  = 2'b10;
    bus.illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = mem_done;
        bus.pc_write  = mem_done;
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = BSelFour;
      end
      StDecode, StAuipc: begin
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = BSelImm;
      end
      StExecR: alu_op4 = {bus.funct7[5], bus.funct3};
      StExecI: begin
        alu_op4       = {(bus.funct3 == 3'b101) & bus.funct7[5], bus.funct3};
        bus.alu_b_sel = BSelImm;
      end
      StWbAlu: bus.reg_write = 1'b1;
      StLui: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WbSelImm;
      end
      StMemAddr: begin
        bus.alu_b_sel = BSelImm;
        bus.mem_size  = bus.funct3[1:0];
      end
      StMemRd: begin
        bus.mem_read = 1'b1;
        bus.mem_size = bus.funct3[1:0];
      end
      StMemWb: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WbSelMem;
        bus.mem_size  = bus.funct3[1:0];
      end
      StMemWr: begin
        bus.mem_write = 1'b1;
        bus.mem_size  = bus.funct3[1:0];
      end
      StJal: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WbSelPc4;
        bus.pc_write  = 1'b1;
        bus.pc_sel    = 1'b1;
      end
      StJalr: begin
        bus.alu_b_sel = BSelImm;
        bus.reg_write = 1'b1;
        bus.wb_sel    = WbSelPc4;
        bus.pc_write  = 1'b1;
      end
      StBrCmp: alu_op4 = ALU_SUB;
      StBrDone: begin
        bus.pc_write = br_taken;
        bus.pc_sel   = 1'b1;
      end
      StIllegal: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.alu_op  = ALU_OP_W'(alu_op4);
  assign bus.state_o = STATE_W'(state_q);

endmodule
